// File: rtl/encoder_pkg.sv
// Shared constants, FSM state type and frame field helper for the encoder poller.
package encoder_pkg;

  localparam int FRAME_W = 24;
  localparam int POS_W   = 19;
  localparam int POS_LSB = 3;
  localparam int POS_MSB = 21;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    STORE
  } poll_state_t;

  // Position field of a raw encoder frame (status/CRC bits around it are discarded).
  function automatic logic [POS_W-1:0] frame_pos(input logic [FRAME_W-1:0] frame);
    return frame[POS_MSB:POS_LSB];
  endfunction

endpackage

// File: rtl/enc_period_timer.sv
// Free-running sweep period counter; tick marks the wrap cycle, enable low holds it at zero.
module enc_period_timer #(
  parameter int PERIOD_CYC = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;

  logic [CNT_W-1:0] count;

  assign tick = enable && (count == CNT_W'(PERIOD_CYC - 1));

  // Count while enabled, restart from zero on wrap or when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!enable || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/encoder_poll_scheduler.sv
// Schedules periodic sweeps and on-demand reads of N_CH SPI encoders over one frame engine,
// keeping a per-channel position bank with valid and sticky timeout status.
module encoder_poll_scheduler
  import encoder_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CH_W        = $clog2(N_CH),
  parameter int PERIOD_CYC  = 50000,
  parameter int TIMEOUT_CYC = 32768
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  req_valid,
  input  logic [CH_W-1:0]       req_ch,
  output logic                  req_ready,
  output logic                  spi_start,
  output logic [CH_W-1:0]       spi_sel,
  input  logic                  spi_busy,
  input  logic                  spi_done,
  input  logic [FRAME_W-1:0]    spi_frame,
  output logic [N_CH*POS_W-1:0] pos_out,
  output logic [N_CH-1:0]       pos_valid,
  output logic                  upd_pulse,
  output logic [CH_W-1:0]       upd_ch,
  output logic [N_CH-1:0]       err_timeout,
  input  logic [N_CH-1:0]       err_clr,
  output logic                  overrun
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  poll_state_t      state, state_next;
  logic [CH_W-1:0]  sel;
  logic             from_req;      // current frame serves the request slot, not the sweep
  logic             slot_full;
  logic [CH_W-1:0]  slot_ch;
  logic [N_CH-1:0]  mask;
  logic [TO_W-1:0]  wait_cnt;
  logic [POS_W-1:0] pos_cap;
  logic             ovr;
  logic             tick;
  logic [CH_W-1:0]  win_ch;
  logic             work_pending;
  logic             timeout_hit;
  logic             consume;
  logic             req_in_range;

  enc_period_timer #(.PERIOD_CYC(PERIOD_CYC)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .tick   (tick)
  );

  assign req_ready    = !slot_full;
  assign req_in_range = ({1'b0, req_ch} < (CH_W + 1)'(N_CH));
  assign work_pending = slot_full || (|mask);
  assign timeout_hit  = (state == WAIT) && !spi_done && (wait_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign consume      = (state == STORE) || timeout_hit;
  assign spi_sel      = sel;
  assign overrun      = ovr;

  // Winner: the request slot first, otherwise the lowest pending sweep channel.
  always_comb begin
    win_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask[i]) win_ch = CH_W'(i);
    end
    if (slot_full) win_ch = slot_ch;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next state and frame-engine / update strobes.
  always_comb begin
    state_next = state;
    spi_start  = 1'b0;
    upd_pulse  = 1'b0;
    upd_ch     = '0;
    case (state)
      IDLE:  if (work_pending && !spi_busy) state_next = ISSUE;
      ISSUE: begin
        spi_start  = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (spi_done)         state_next = STORE;
        else if (timeout_hit) state_next = IDLE;
      end
      STORE: begin
        upd_pulse  = 1'b1;
        upd_ch     = sel;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Frame bookkeeping: channel latch, timeout counter, frame capture, work queue, overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel       <= '0;
      from_req  <= 1'b0;
      wait_cnt  <= '0;
      pos_cap   <= '0;
      slot_full <= 1'b0;
      slot_ch   <= '0;
      mask      <= '0;
      ovr       <= 1'b0;
    end else begin
      if (state == IDLE && state_next == ISSUE) begin
        sel      <= win_ch;
        from_req <= slot_full;
      end
      if (state == ISSUE)     wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
      if (state == WAIT && spi_done) pos_cap <= frame_pos(spi_frame);
      // Out-of-range requests are accepted but never occupy the slot.
      if (req_valid && req_ready && req_in_range) begin
        slot_full <= 1'b1;
        slot_ch   <= req_ch;
      end
      if (consume && from_req) slot_full <= 1'b0;
      // A tick re-arms every channel; an unfinished sweep is merged, not queued.
      if (!enable)                  mask      <= '0;
      else if (tick)                mask      <= '1;
      else if (consume && !from_req) mask[sel] <= 1'b0;
      ovr <= tick && (|mask);
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [POS_W-1:0] pos_reg;
    logic             valid_reg;
    logic             err_reg;
    logic             hit;

    assign hit = (sel == CH_W'(gi));
    assign pos_out[gi*POS_W +: POS_W] = pos_reg;
    assign pos_valid[gi]   = valid_reg;
    assign err_timeout[gi] = err_reg;

    // Per-channel bank update; a timeout set beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pos_reg   <= '0;
        valid_reg <= 1'b0;
        err_reg   <= 1'b0;
      end else begin
        if (state == STORE && hit) begin
          pos_reg   <= pos_cap;
          valid_reg <= 1'b1;
        end
        err_reg <= (err_reg && !err_clr[gi]) || (timeout_hit && hit);
      end
    end
  end

endmodule

// File: tb/tb_encoder_poll_scheduler.sv
// Scenario bench for encoder_poll_scheduler with a behavioural SPI frame engine and event scoreboard.
module tb_encoder_poll_scheduler;

  localparam int N_CH = 4;
  localparam int CH_W = 2;
  localparam int POS_W = 19;
  localparam int PERIOD_CYC = 200;
  localparam int TIMEOUT_CYC = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic req_valid = 1'b0;
  logic [CH_W-1:0] req_ch = '0;
  logic req_ready, spi_start, upd_pulse, overrun;
  logic [CH_W-1:0] spi_sel, upd_ch;
  logic spi_busy = 1'b0;
  logic spi_done = 1'b0;
  logic [23:0] spi_frame = '0;
  logic [N_CH*POS_W-1:0] pos_out;
  logic [N_CH-1:0] pos_valid, err_timeout;
  logic [N_CH-1:0] err_clr = '0;

  always #5 clk = ~clk;

  encoder_poll_scheduler #(
    .N_CH(N_CH), .CH_W(CH_W), .PERIOD_CYC(PERIOD_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req_valid(req_valid), .req_ch(req_ch),
    .req_ready(req_ready), .spi_start(spi_start), .spi_sel(spi_sel), .spi_busy(spi_busy),
    .spi_done(spi_done), .spi_frame(spi_frame), .pos_out(pos_out), .pos_valid(pos_valid),
    .upd_pulse(upd_pulse), .upd_ch(upd_ch), .err_timeout(err_timeout), .err_clr(err_clr),
    .overrun(overrun)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame engine model: responds delay cycles after start unless the channel is dropped.
  logic [23:0] frames [N_CH];
  logic [N_CH-1:0] drop = '0;
  int delay = 30;

  initial begin : engine
    int cnt;
    int ech;
    cnt = 0;
    ech = 0;
    forever begin
      @(posedge clk);
      #2;
      spi_done = 1'b0;
      if (!rst_n) begin
        spi_busy = 1'b0;
        cnt = 0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          spi_busy = 1'b0;
          if (!drop[ech]) begin
            spi_frame = frames[ech];
            spi_done = 1'b1;
          end
        end
      end else if (spi_start) begin
        ech = int'(spi_sel);
        spi_busy = 1'b1;
        cnt = delay;
      end
    end
  end

  // Event logs filled by the monitor; scoreboards hold what each scenario expects.
  int start_ch_q[$], start_cyc_q[$], upd_ch_q[$], upd_cyc_q[$];
  int done_cyc_q[$], ovr_cyc_q[$], err_cyc_q[$];
  int exp_start_q[$], exp_upd_q[$];
  logic err1_prev = 1'b0;

  always @(negedge clk) begin
    if (spi_start) begin
      start_ch_q.push_back(int'(spi_sel));
      start_cyc_q.push_back(cyc);
    end
    if (upd_pulse) begin
      upd_ch_q.push_back(int'(upd_ch));
      upd_cyc_q.push_back(cyc);
    end
    if (spi_done) done_cyc_q.push_back(cyc);
    if (overrun) ovr_cyc_q.push_back(cyc);
    if (err_timeout[1] && !err1_prev) err_cyc_q.push_back(cyc);
    err1_prev <= err_timeout[1];
  end

  task automatic clear_logs();
    start_ch_q.delete(); start_cyc_q.delete(); upd_ch_q.delete(); upd_cyc_q.delete();
    done_cyc_q.delete(); ovr_cyc_q.delete(); err_cyc_q.delete();
    exp_start_q.delete(); exp_upd_q.delete();
  endtask

  task automatic wait_starts(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (start_ch_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (start_ch_q.size() >= n);
  endtask

  task automatic wait_upds(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (upd_ch_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (upd_ch_q.size() >= n);
  endtask

  task automatic quiesce();
    @(negedge clk);
    enable = 1'b0;
    repeat (150) @(negedge clk);
    clear_logs();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors += 8;
    if (pos_out !== '0) begin miscompares++; $display("FAIL reset_pos_out got %h want 0", pos_out); end
    if (pos_valid !== 4'h0) begin miscompares++; $display("FAIL reset_pos_valid got %h want 0", pos_valid); end
    if (err_timeout !== 4'h0) begin miscompares++; $display("FAIL reset_err got %h want 0", err_timeout); end
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    if (spi_start !== 1'b0) begin miscompares++; $display("FAIL reset_spi_start got %b want 0", spi_start); end
    if (upd_pulse !== 1'b0) begin miscompares++; $display("FAIL reset_upd_pulse got %b want 0", upd_pulse); end
    if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got %b want 0", overrun); end
    if (spi_sel !== 2'd0) begin miscompares++; $display("FAIL reset_spi_sel got %0d want 0", spi_sel); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok;
    int e, a, rel;
    delay = 10;
    drop = 4'b0010;
    exp_start_q = '{0, 1, 2, 3};
    exp_upd_q = '{0, 2, 3};
    enable = 1'b1;
    wait_upds(3, 700, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL timeout_wait got %0d updates want 3", upd_ch_q.size()); end
    rel = (start_cyc_q.size() > 1 && err_cyc_q.size() > 0) ? err_cyc_q[0] - start_cyc_q[1] : -1;
    vectors++;
    if (rel < TIMEOUT_CYC || rel > TIMEOUT_CYC + 1) begin
      miscompares++; $display("FAIL timeout_latency got %0d cycles want %0d..%0d", rel, TIMEOUT_CYC, TIMEOUT_CYC + 1);
    end
    while (exp_start_q.size() > 0) begin
      e = exp_start_q.pop_front();
      a = (start_ch_q.size() > 0) ? start_ch_q.pop_front() : -1;
      vectors++;
      if (a !== e) begin miscompares++; $display("FAIL timeout_start_order got ch %0d want ch %0d", a, e); end
    end
    while (exp_upd_q.size() > 0) begin
      e = exp_upd_q.pop_front();
      a = (upd_ch_q.size() > 0) ? upd_ch_q.pop_front() : -1;
      vectors++;
      if (a !== e) begin miscompares++; $display("FAIL timeout_upd_ch got ch %0d want ch %0d", a, e); end
    end
    quiesce();
    vectors += 2;
    if (pos_valid !== 4'b1101) begin miscompares++; $display("FAIL timeout_pos_valid got %b want 1101", pos_valid); end
    if (err_timeout !== 4'b0010) begin miscompares++; $display("FAIL timeout_flag got %b want 0010", err_timeout); end
    err_clr = 4'b0010;
    @(negedge clk);
    err_clr = 4'b0000;
    vectors++;
    if (err_timeout !== 4'b0000) begin miscompares++; $display("FAIL timeout_clear got %b want 0000", err_timeout); end
    drop = 4'b0000;
  endtask

  task automatic test_sweep();
    bit ok;
    int e, a;
    delay = 30;
    exp_start_q = '{0, 1, 2, 3};
    exp_upd_q = '{0, 1, 2, 3};
    enable = 1'b1;
    wait_upds(4, 600, ok);
    repeat (2) @(negedge clk);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL sweep_wait got %0d updates want 4", upd_ch_q.size()); end
    while (exp_start_q.size() > 0) begin
      e = exp_start_q.pop_front();
      a = (start_ch_q.size() > 0) ? start_ch_q.pop_front() : -1;
      vectors++;
      if (a !== e) begin miscompares++; $display("FAIL sweep_start_order got ch %0d want ch %0d", a, e); end
    end
    while (exp_upd_q.size() > 0) begin
      e = exp_upd_q.pop_front();
      a = (upd_ch_q.size() > 0) ? upd_ch_q.pop_front() : -1;
      vectors++;
      if (a !== e) begin miscompares++; $display("FAIL sweep_upd_ch got ch %0d want ch %0d", a, e); end
    end
    vectors += 6;
    if (start_ch_q.size() != 0) begin miscompares++; $display("FAIL sweep_extra_starts got %0d want 0", start_ch_q.size()); end
    if (pos_out[0*POS_W +: POS_W] !== 19'h4B4B4) begin miscompares++; $display("FAIL sweep_pos0 got %h want 4b4b4", pos_out[0*POS_W +: POS_W]); end
    if (pos_out[1*POS_W +: POS_W] !== 19'h2468A) begin miscompares++; $display("FAIL sweep_pos1 got %h want 2468a", pos_out[1*POS_W +: POS_W]); end
    if (pos_out[2*POS_W +: POS_W] !== 19'h7FFFF) begin miscompares++; $display("FAIL sweep_pos2 got %h want 7ffff", pos_out[2*POS_W +: POS_W]); end
    if (pos_out[3*POS_W +: POS_W] !== 19'h00001) begin miscompares++; $display("FAIL sweep_pos3 got %h want 00001", pos_out[3*POS_W +: POS_W]); end
    if (pos_valid !== 4'hF) begin miscompares++; $display("FAIL sweep_pos_valid got %h want f", pos_valid); end
    quiesce();
  endtask

  task automatic test_request();
    bit ok;
    int a, lat;
    frames[2] = 24'h3C3C3C;
    @(negedge clk);
    req_valid = 1'b1;
    req_ch = 2'd2;
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL req_ready_idle got %b want 1", req_ready); end
    @(negedge clk);
    vectors += 2;
    if (req_ready !== 1'b0) begin miscompares++; $display("FAIL req_ready_full got %b want 0", req_ready); end
    if (spi_start !== 1'b0) begin miscompares++; $display("FAIL req_start_early got %b want 0", spi_start); end
    req_valid = 1'b0;
    exp_upd_q.push_back(2);
    @(negedge clk);
    vectors += 2;
    if (spi_start !== 1'b1) begin miscompares++; $display("FAIL req_start_latency got %b want 1", spi_start); end
    if (spi_sel !== 2'd2) begin miscompares++; $display("FAIL req_spi_sel got %0d want 2", spi_sel); end
    wait_upds(1, 100, ok);
    repeat (2) @(negedge clk);
    a = (upd_ch_q.size() > 0) ? upd_ch_q.pop_front() : -1;
    lat = (upd_cyc_q.size() > 0 && done_cyc_q.size() > 0) ? upd_cyc_q[0] - done_cyc_q[0] : -1;
    vectors += 6;
    if (a !== exp_upd_q.pop_front()) begin miscompares++; $display("FAIL req_upd_ch got ch %0d want ch 2", a); end
    if (lat != 1) begin miscompares++; $display("FAIL req_upd_latency got %0d want 1", lat); end
    if (pos_out[2*POS_W +: POS_W] !== 19'h78787) begin miscompares++; $display("FAIL req_pos2 got %h want 78787", pos_out[2*POS_W +: POS_W]); end
    if (pos_out[0*POS_W +: POS_W] !== 19'h4B4B4) begin miscompares++; $display("FAIL req_pos0_kept got %h want 4b4b4", pos_out[0*POS_W +: POS_W]); end
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL req_ready_after got %b want 1", req_ready); end
    if (start_ch_q.size() != 1) begin miscompares++; $display("FAIL req_start_count got %0d want 1", start_ch_q.size()); end
    quiesce();
  endtask

  task automatic test_overrun();
    bit ok;
    int e, a, c0, rel;
    delay = 70;
    // Tick 2 lands while ch2 is in flight: all bits re-armed, then ch2's completion clears its bit.
    exp_start_q = '{0, 1, 2, 0, 1, 3};
    @(negedge clk);
    c0 = cyc;
    enable = 1'b1;
    wait_upds(6, 900, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL overrun_wait got %0d updates want 6", upd_ch_q.size()); end
    rel = (ovr_cyc_q.size() > 0) ? ovr_cyc_q[0] - c0 : -1;
    vectors++;
    if (rel != 2 * PERIOD_CYC) begin miscompares++; $display("FAIL overrun_cycle got %0d want %0d", rel, 2 * PERIOD_CYC); end
    while (exp_start_q.size() > 0) begin
      e = exp_start_q.pop_front();
      a = (start_ch_q.size() > 0) ? start_ch_q.pop_front() : -1;
      exp_upd_q.push_back(e);
      vectors++;
      if (a !== e) begin miscompares++; $display("FAIL overrun_start_order got ch %0d want ch %0d", a, e); end
    end
    while (exp_upd_q.size() > 0) begin
      e = exp_upd_q.pop_front();
      a = (upd_ch_q.size() > 0) ? upd_ch_q.pop_front() : -1;
      vectors++;
      if (a !== e) begin miscompares++; $display("FAIL overrun_upd_ch got ch %0d want ch %0d", a, e); end
    end
    quiesce();
    delay = 30;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int e, a;
    exp_start_q = '{0, 3, 1, 2, 3};
    exp_upd_q = '{0, 3, 1, 2, 3};
    enable = 1'b1;
    wait_starts(1, 400, ok);
    repeat (5) @(negedge clk);
    req_valid = 1'b1;
    req_ch = 2'd3;
    @(negedge clk);
    req_valid = 1'b0;
    wait_upds(5, 400, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL midsweep_wait got %0d updates want 5", upd_ch_q.size()); end
    while (exp_start_q.size() > 0) begin
      e = exp_start_q.pop_front();
      a = (start_ch_q.size() > 0) ? start_ch_q.pop_front() : -1;
      vectors++;
      if (a !== e) begin miscompares++; $display("FAIL midsweep_start_order got ch %0d want ch %0d", a, e); end
    end
    while (exp_upd_q.size() > 0) begin
      e = exp_upd_q.pop_front();
      a = (upd_ch_q.size() > 0) ? upd_ch_q.pop_front() : -1;
      vectors++;
      if (a !== e) begin miscompares++; $display("FAIL midsweep_upd_ch got ch %0d want ch %0d", a, e); end
    end
    vectors++;
    if (start_ch_q.size() != 0) begin miscompares++; $display("FAIL midsweep_extra_starts got %0d want 0", start_ch_q.size()); end
    quiesce();
  endtask

  task automatic test_async_reset();
    bit ok;
    int c0, rel, a;
    enable = 1'b1;
    wait_starts(1, 400, ok);
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors += 6;
    if (pos_out !== '0) begin miscompares++; $display("FAIL areset_pos_out got %h want 0", pos_out); end
    if (pos_valid !== 4'h0) begin miscompares++; $display("FAIL areset_pos_valid got %h want 0", pos_valid); end
    if (spi_start !== 1'b0) begin miscompares++; $display("FAIL areset_spi_start got %b want 0", spi_start); end
    if (upd_pulse !== 1'b0) begin miscompares++; $display("FAIL areset_upd_pulse got %b want 0", upd_pulse); end
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL areset_req_ready got %b want 1", req_ready); end
    if (err_timeout !== 4'h0) begin miscompares++; $display("FAIL areset_err got %h want 0", err_timeout); end
    repeat (2) @(negedge clk);
    clear_logs();
    c0 = cyc;
    rst_n = 1'b1;
    wait_starts(1, 400, ok);
    rel = (start_cyc_q.size() > 0) ? start_cyc_q[0] - c0 : -1;
    a = (start_ch_q.size() > 0) ? start_ch_q[0] : -1;
    vectors += 2;
    if (rel != PERIOD_CYC + 1) begin miscompares++; $display("FAIL areset_first_start got %0d cycles want %0d", rel, PERIOD_CYC + 1); end
    if (a != 0) begin miscompares++; $display("FAIL areset_first_ch got ch %0d want ch 0", a); end
    enable = 1'b0;
  endtask

  initial begin
    frames[0] = 24'hA5A5A5;
    frames[1] = 24'h123456;
    frames[2] = 24'hFFFFFF;
    frames[3] = 24'h000008;
    test_reset();
    test_timeout();
    test_sweep();
    test_request();
    test_overrun();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
